// File: rtl/calc_datapath.sv
// calc_datapath: register file (top two entries are PC and LR), single-cycle ALU,
// iterative shift-add multiplier and Z/C flags between the decoder and the memory/IO bus.
// Ops 1-6 write at the same edge; a MUL holds halt_o for DATA_W+1 cycles and writes on the DONE edge.
module calc_datapath #(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 8,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SEL_W-1:0]           rd_sel_a_i,
    input  logic [SEL_W-1:0]           rd_sel_b_i,
    input  logic [SEL_W-1:0]           wr_sel_i,
    input  logic [1:0]                 src_sel_i,
    input  logic [2:0]                 alu_op_i,
    input  logic                       b_ext_i,
    input  logic                       rd_only_i,
    input  logic                       pc_inc_i,
    input  logic [DATA_W-1:0]          ext_val_i,
    output logic [DATA_W-1:0]          ext_val_o,
    output logic [DATA_W-1:0]          ext_addr_o,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [1:0]                 flags_o,
    output logic                       halt_o
);
    localparam int PC_IDX = NUM_REGS - 2;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic                  flag_c, flag_z;
    logic [2*DATA_W-1:0]   mcand, acc;
    logic [DATA_W-1:0]     mplier;
    logic [CNT_W-1:0]      cnt;
    logic                  halt_busy;
    logic [DATA_W-1:0]     op_a, reg_b, op_b;
    logic [DATA_W-1:0]     alu_res, wr_dat;
    logic                  alu_c, alu_vld, wr_en;

    assign op_a       = regs[rd_sel_a_i];
    assign reg_b      = regs[rd_sel_b_i];
    assign op_b       = b_ext_i ? ext_val_i : reg_b;
    assign ext_val_o  = op_a;
    assign ext_addr_o = reg_b;
    assign flags_o    = {flag_c, flag_z};
    // The decoder may still present MUL while in reset; keep the stall low then.
    assign halt_o     = halt_busy & ~rst;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_W +: DATA_W] = regs[g];
    end

    // ALU: result, carry and validity; MUL result is only valid on the DONE cycle
    always_comb begin
        alu_res = '0;
        alu_c   = flag_c;
        alu_vld = 1'b1;
        case (alu_op_i)
            OP_ADD: {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB: {alu_c, alu_res} = {1'b0, op_a} - {1'b0, op_b};
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SHL: begin
                alu_res = {op_a[DATA_W-2:0], 1'b0};
                alu_c   = op_a[DATA_W-1];
            end
            OP_MUL: begin
                alu_res = acc[DATA_W-1:0];
                alu_c   = |acc[2*DATA_W-1:DATA_W];
                alu_vld = (state == S_DONE);
            end
            default: alu_vld = 1'b0;
        endcase
    end

    // Write source selection and enable
    always_comb begin
        wr_dat = op_a;
        case (src_sel_i)
            2'd0:    wr_dat = op_a;
            2'd1:    wr_dat = ext_val_i;
            2'd2:    wr_dat = alu_res;
            default: wr_dat = reg_b;
        endcase
        wr_en = ~rd_only_i & ~halt_busy & ((src_sel_i != 2'd2) | alu_vld);
    end

    // Multiplier FSM next state and stall
    always_comb begin
        state_nxt = state;
        halt_busy = 1'b0;
        case (state)
            S_IDLE: begin
                if (alu_op_i == OP_MUL) begin
                    halt_busy = 1'b1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                halt_busy = 1'b1;
                if (cnt == CNT_W'(DATA_W - 1)) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Shift-add multiplier: latch operands on issue, one partial product per BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == S_IDLE && alu_op_i == OP_MUL) begin
            mcand  <= {{DATA_W{1'b0}}, op_a};
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == S_BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Flags follow every valid ALU result, even when the register write is suppressed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (alu_vld) begin
            flag_c <= alu_c;
            flag_z <= (alu_res == '0);
        end
    end

    // Register file; an explicit write to PC overrides the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (pc_inc_i && !halt_busy) regs[PC_IDX] <= regs[PC_IDX] + DATA_W'(1);
            if (wr_en) regs[wr_sel_i] <= wr_dat;
        end
    end
endmodule

// File: tb/tb_calc_datapath.sv
// Bench for calc_datapath: directed scenarios plus random ops against an arithmetic model.
// Two instances: default 8-bit/8-reg and 16-bit/16-reg.
module tb_calc_datapath;
    localparam int W = 8, N = 8, S = 3, PC = N - 2;
    localparam int MAX = 1 << W;
    localparam int W2 = 16, N2 = 16, S2 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [S-1:0] ra = '0, rb = '0, wr = '0;
    logic [1:0]   src = '0;
    logic [2:0]   op = '0;
    logic         bext = 1'b0, rdo = 1'b1, pci = 1'b0;
    logic [W-1:0] ev = '0;
    logic [W-1:0] ext_val_o, ext_addr_o;
    logic [N*W-1:0] regs_o;
    logic [1:0]   flags_o;
    logic         halt_o;

    logic [S2-1:0] q_ra = '0, q_rb = '0, q_wr = '0;
    logic [1:0]    q_src = '0;
    logic [2:0]    q_op = '0;
    logic          q_bext = 1'b0, q_rdo = 1'b1, q_pci = 1'b0;
    logic [W2-1:0] q_ev = '0;
    logic [W2-1:0] q_ext_val_o, q_ext_addr_o;
    logic [N2*W2-1:0] q_regs_o;
    logic [1:0]    q_flags_o;
    logic          q_halt_o;

    int total = 0, bad = 0;

    calc_datapath dut (
        .clk(clk), .rst(rst), .rd_sel_a_i(ra), .rd_sel_b_i(rb), .wr_sel_i(wr),
        .src_sel_i(src), .alu_op_i(op), .b_ext_i(bext), .rd_only_i(rdo), .pc_inc_i(pci),
        .ext_val_i(ev), .ext_val_o(ext_val_o), .ext_addr_o(ext_addr_o), .regs_o(regs_o),
        .flags_o(flags_o), .halt_o(halt_o)
    );

    calc_datapath #(.DATA_W(W2), .NUM_REGS(N2)) dut16 (
        .clk(clk), .rst(rst), .rd_sel_a_i(q_ra), .rd_sel_b_i(q_rb), .wr_sel_i(q_wr),
        .src_sel_i(q_src), .alu_op_i(q_op), .b_ext_i(q_bext), .rd_only_i(q_rdo), .pc_inc_i(q_pci),
        .ext_val_i(q_ev), .ext_val_o(q_ext_val_o), .ext_addr_o(q_ext_addr_o), .regs_o(q_regs_o),
        .flags_o(q_flags_o), .halt_o(q_halt_o)
    );

    // Reference model state
    logic [W-1:0] m_regs [N];
    logic         m_c, m_z;

    function automatic logic [N*W-1:0] model_flat();
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_c = 1'b0;
        m_z = 1'b0;
    endtask

    // One architectural step from the current inputs (for MUL: the completing cycle)
    task automatic model_apply();
        int a, b, r, wv;
        logic c_n, vld, we;
        a = int'(m_regs[ra]);
        b = bext ? int'(ev) : int'(m_regs[rb]);
        r = 0; c_n = m_c; vld = 1'b1;
        case (op)
            3'd1: begin r = a + b; c_n = (r >= MAX); r = r % MAX; end
            3'd2: begin c_n = (a < b); r = (a - b + MAX) % MAX; end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin c_n = (a >= MAX / 2); r = (a * 2) % MAX; end
            3'd7: begin r = a * b; c_n = (r >= MAX); r = r % MAX; end
            default: vld = 1'b0;
        endcase
        case (src)
            2'd0:    wv = int'(m_regs[ra]);
            2'd1:    wv = int'(ev);
            2'd2:    wv = r;
            default: wv = int'(m_regs[rb]);
        endcase
        we = !rdo && (src != 2'd2 || vld);
        if (vld) begin m_c = c_n; m_z = (r == 0); end
        if (we) m_regs[wr] = W'(wv);
        if (pci && !(we && int'(wr) == PC)) m_regs[PC] = W'((int'(m_regs[PC]) + 1) % MAX);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [S-1:0] a_, input logic [S-1:0] b_, input logic [S-1:0] w_,
                         input logic [1:0] s_, input logic [2:0] o_, input logic bx,
                         input logic ro, input logic pi, input logic [W-1:0] e);
        ra = a_; rb = b_; wr = w_; src = s_; op = o_; bext = bx; rdo = ro; pci = pi; ev = e;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic load(input logic [S-1:0] idx, input logic [W-1:0] val);
        drive(0, 0, idx, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, val);
        model_apply();
        tick();
    endtask

    // Issue a MUL, count stall cycles, capture regs just before the completing edge
    task automatic do_mul(input logic [S-1:0] a_, input logic [S-1:0] b_, input logic [S-1:0] w_,
                          input logic [1:0] s_, input logic bx, input logic ro, input logic pi,
                          input logic [W-1:0] e, output int n, output logic [N*W-1:0] pre);
        drive(a_, b_, w_, s_, 3'd7, bx, ro, pi, e);
        n = 0;
        while (halt_o === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        pre = regs_o;
        model_apply();
        tick();
        idle();
    endtask

    task automatic test_reset();
        #3;
        total++; if (regs_o !== '0) begin bad++; $display("FAIL rst_regs got=%h exp=0", regs_o); end
        total++; if (flags_o !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", flags_o); end
        total++; if (halt_o !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b exp=0", halt_o); end
        tick();
        rst = 1'b0;
        model_reset();
        load(0, 8'h55);
        load(1, 8'h03);
        drive(0, 1, 3, 2'd2, 3'd7, 1'b0, 1'b0, 1'b0, '0);
        tick();
        #2 rst = 1'b1;
        #1;
        total++; if (regs_o !== '0) begin bad++; $display("FAIL async_rst_regs got=%h exp=0", regs_o); end
        total++; if (halt_o !== 1'b0) begin bad++; $display("FAIL async_rst_halt got=%b exp=0", halt_o); end
        total++; if (flags_o !== 2'b00) begin bad++; $display("FAIL async_rst_flags got=%b exp=00", flags_o); end
        idle();
        rst = 1'b0;
        model_reset();
        load(0, 8'h12);
        total++; if (regs_o[7:0] !== 8'h12) begin bad++; $display("FAIL r0_after_rst got=%h exp=12", regs_o[7:0]); end
    endtask

    task automatic test_add_sub();
        load(0, 8'hF0);
        load(1, 8'h20);
        drive(0, 1, 2, 2'd2, 3'd1, 1'b0, 1'b0, 1'b0, '0);
        model_apply();
        tick();
        total++; if (regs_o[2*W +: W] !== 8'h10) begin bad++; $display("FAIL add_r2 got=%h exp=10", regs_o[2*W +: W]); end
        total++; if (flags_o !== 2'b10) begin bad++; $display("FAIL add_flags got=%b exp=10", flags_o); end
        drive(1, 1, 2, 2'd2, 3'd2, 1'b0, 1'b1, 1'b0, '0);
        model_apply();
        tick();
        total++; if (regs_o[2*W +: W] !== 8'h10) begin bad++; $display("FAIL cmp_nowrite got=%h exp=10", regs_o[2*W +: W]); end
        total++; if (flags_o !== 2'b01) begin bad++; $display("FAIL cmp_flags got=%b exp=01", flags_o); end
        idle();
    endtask

    task automatic test_mul();
        int n;
        logic [N*W-1:0] pre;
        load(0, 8'h0D);
        load(1, 8'h0B);
        do_mul(0, 1, 3, 2'd2, 1'b0, 1'b0, 1'b0, '0, n, pre);
        total++; if (n !== 9) begin bad++; $display("FAIL mul_halt_cycles got=%0d exp=9", n); end
        total++; if (pre[3*W +: W] !== 8'h00) begin bad++; $display("FAIL mul_early_write got=%h exp=00", pre[3*W +: W]); end
        total++; if (regs_o[3*W +: W] !== 8'h8F) begin bad++; $display("FAIL mul_r3 got=%h exp=8f", regs_o[3*W +: W]); end
        total++; if (flags_o !== 2'b00) begin bad++; $display("FAIL mul_flags got=%b exp=00", flags_o); end
        load(0, 8'h20);
        load(1, 8'h10);
        do_mul(0, 1, 3, 2'd2, 1'b0, 1'b0, 1'b0, '0, n, pre);
        total++; if (regs_o[3*W +: W] !== 8'h00) begin bad++; $display("FAIL mul_ovf_r3 got=%h exp=00", regs_o[3*W +: W]); end
        total++; if (flags_o !== 2'b11) begin bad++; $display("FAIL mul_ovf_flags got=%b exp=11", flags_o); end
    endtask

    task automatic test_mul_reset();
        load(0, 8'h07);
        load(1, 8'h05);
        drive(0, 1, 3, 2'd2, 3'd7, 1'b0, 1'b0, 1'b0, '0);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        total++; if (halt_o !== 1'b0) begin bad++; $display("FAIL mulrst_halt got=%b exp=0", halt_o); end
        idle();
        rst = 1'b0;
        model_reset();
        repeat (12) tick();
        total++; if (regs_o !== '0) begin bad++; $display("FAIL mulrst_regs got=%h exp=0", regs_o); end
        total++; if (halt_o !== 1'b0) begin bad++; $display("FAIL mulrst_halt_after got=%b exp=0", halt_o); end
    endtask

    task automatic test_pc();
        int n;
        logic [N*W-1:0] pre;
        logic [W-1:0] exp_pc [3];
        exp_pc[0] = 8'hFF; exp_pc[1] = 8'h00; exp_pc[2] = 8'h01;
        load(PC, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1, '0);
            model_apply();
            tick();
            total++; if (regs_o[PC*W +: W] !== exp_pc[i]) begin bad++; $display("FAIL pc_inc%0d got=%h exp=%h", i, regs_o[PC*W +: W], exp_pc[i]); end
        end
        drive(0, 0, PC, 2'd1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h40);
        model_apply();
        tick();
        total++; if (regs_o[PC*W +: W] !== 8'h40) begin bad++; $display("FAIL pc_write_wins got=%h exp=40", regs_o[PC*W +: W]); end
        load(0, 8'h03);
        load(1, 8'h04);
        do_mul(0, 1, 3, 2'd2, 1'b0, 1'b0, 1'b1, '0, n, pre);
        total++; if (regs_o[PC*W +: W] !== 8'h41) begin bad++; $display("FAIL pc_mul_halt got=%h exp=41", regs_o[PC*W +: W]); end
        total++; if (regs_o[3*W +: W] !== 8'h0C) begin bad++; $display("FAIL pc_mul_r3 got=%h exp=0c", regs_o[3*W +: W]); end
    endtask

    task automatic test_random();
        int n;
        logic [N*W-1:0] pre;
        for (int it = 0; it < 150; it++) begin
            logic [S-1:0] a_, b_, w_;
            logic [1:0] s_;
            logic [2:0] o_;
            logic bx, ro, pi;
            logic [W-1:0] e;
            a_ = S'($urandom); b_ = S'($urandom); w_ = S'($urandom);
            s_ = 2'($urandom); o_ = 3'($urandom); e = W'($urandom);
            bx = 1'($urandom); ro = ($urandom_range(0, 3) == 0); pi = 1'($urandom);
            if (o_ == 3'd7) begin
                do_mul(a_, b_, w_, s_, bx, ro, pi, e, n, pre);
                total++; if (n !== W + 1) begin bad++; $display("FAIL rnd_mul_halt it=%0d got=%0d exp=%0d", it, n, W + 1); end
            end else begin
                drive(a_, b_, w_, s_, o_, bx, ro, pi, e);
                total++; if (ext_val_o !== m_regs[a_] || ext_addr_o !== m_regs[b_]) begin
                    bad++; $display("FAIL rnd_ext it=%0d got=%h/%h exp=%h/%h", it, ext_val_o, ext_addr_o, m_regs[a_], m_regs[b_]);
                end
                model_apply();
                tick();
            end
            total++; if (regs_o !== model_flat()) begin bad++; $display("FAIL rnd_regs it=%0d got=%h exp=%h", it, regs_o, model_flat()); end
            total++; if (flags_o !== {m_c, m_z}) begin bad++; $display("FAIL rnd_flags it=%0d got=%b exp=%b", it, flags_o, {m_c, m_z}); end
        end
        idle();
    endtask

    task automatic drive16(input logic [S2-1:0] a_, input logic [S2-1:0] b_, input logic [S2-1:0] w_,
                           input logic [1:0] s_, input logic [2:0] o_, input logic ro, input logic [W2-1:0] e);
        q_ra = a_; q_rb = b_; q_wr = w_; q_src = s_; q_op = o_; q_bext = 1'b0; q_rdo = ro; q_pci = 1'b0; q_ev = e;
        #1;
    endtask

    task automatic test_param16();
        int n;
        logic [W2-1:0] exp16 [N2];
        drive16(0, 0, 0, 2'd1, 3'd0, 1'b0, 16'hFFFF); tick();
        drive16(0, 0, 1, 2'd1, 3'd0, 1'b0, 16'h0002); tick();
        drive16(0, 1, 3, 2'd2, 3'd7, 1'b0, '0);
        n = 0;
        while (q_halt_o === 1'b1 && n < 60) begin n++; tick(); end
        tick();
        drive16(0, 0, 0, 2'd0, 3'd0, 1'b1, '0);
        total++; if (n !== 17) begin bad++; $display("FAIL p16_halt_cycles got=%0d exp=17", n); end
        total++; if (q_regs_o[3*W2 +: W2] !== 16'hFFFE) begin bad++; $display("FAIL p16_mul_r3 got=%h exp=fffe", q_regs_o[3*W2 +: W2]); end
        total++; if (q_flags_o !== 2'b10) begin bad++; $display("FAIL p16_mul_flags got=%b exp=10", q_flags_o); end
        for (int i = 0; i < N2; i++) begin
            exp16[i] = W2'($urandom);
            drive16(0, 0, S2'(i), 2'd1, 3'd0, 1'b0, exp16[i]);
            tick();
        end
        drive16(0, 0, 0, 2'd0, 3'd0, 1'b1, '0);
        for (int i = 0; i < N2; i++) begin
            q_rb = S2'(i);
            #1;
            total++; if (q_ext_addr_o !== exp16[i]) begin bad++; $display("FAIL p16_ext_addr sel=%0d got=%h exp=%h", i, q_ext_addr_o, exp16[i]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_add_sub();
        test_mul();
        test_mul_reset();
        test_pc();
        test_random();
        test_param16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
